// File: rtl/hazard_pkg.sv
// Shared opcode classes and FSM encoding for the pipeline hazard controller.
// Opcode values follow the Control_Unit encoding.
package hazard_pkg;

    localparam logic [5:0] OP_LDR      = 6'b101001;
    localparam logic [5:0] OP_MUL      = 6'b000011;
    localparam logic [5:0] OP_MULI     = 6'b001011;
    localparam logic [5:0] OP_JMP      = 6'b111000;
    localparam logic [5:0] OP_NOT_JUMP = 6'b111111;
    localparam logic [2:0] JUMP_PREFIX = 3'b111;

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        return op == OP_LDR;
    endfunction

    function automatic logic is_mul(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MULI);
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op[5:3] == JUMP_PREFIX) && (op != OP_NOT_JUMP);
    endfunction

endpackage

// File: rtl/hazard_ctrl_perf_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush sequencing for load-use, multi-cycle MUL and EX jumps.
// Keeps a private shadow of the EX stage so all strobes are same-cycle.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 3,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_reg_write,
    input  logic              ex_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic              pc_redirect,
    output logic              mul_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam bit         MUL_STALLS = (MUL_LAT > 1);
    localparam logic [3:0] MUL_CNT0   = MUL_STALLS ? 4'(MUL_LAT - 2) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ex_valid_q;
    logic [REG_W-1:0]  ex_rd_q;
    logic              ex_is_load_q;
    logic              ex_is_mul_q;
    logic              ex_is_jump_q;
    logic              ex_is_jmp_q;

    logic br_hit, mul_hit, lu_hit;

    assign br_hit  = ex_valid_q && ex_is_jump_q && (ex_taken || ex_is_jmp_q);
    assign mul_hit = ex_valid_q && ex_is_mul_q && MUL_STALLS;
    assign lu_hit  = ex_valid_q && ex_is_load_q && id_valid &&
                     ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd_q)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        pc_redirect = 1'b0;
        mul_busy    = 1'b0;
        case (state_q)
            RUN: begin
                if (br_hit) begin
                    pc_redirect = 1'b1;
                    flush_id    = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (mul_hit) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    mul_busy = 1'b1;
                    cnt_d    = MUL_CNT0;
                    state_d  = MUL_WAIT;
                end else if (lu_hit) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            MUL_WAIT: begin
                mul_busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load that does not write a register cannot create a load-use hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_is_load_q <= 1'b0;
            ex_is_mul_q  <= 1'b0;
            ex_is_jump_q <= 1'b0;
            ex_is_jmp_q  <= 1'b0;
        end else if (!stall_ex) begin
            if (bubble_ex || flush_id) begin
                ex_valid_q <= 1'b0;
            end else begin
                ex_valid_q   <= id_valid;
                ex_rd_q      <= id_rd;
                ex_is_load_q <= is_load(id_opcode) && id_reg_write;
                ex_is_mul_q  <= is_mul(id_opcode);
                ex_is_jump_q <= is_jump(id_opcode);
                ex_is_jmp_q  <= (id_opcode == OP_JMP);
            end
        end
    end

    perf_sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (stall_if),
        .count_o (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Vector-table bench for hazard_ctrl with an expected-value scoreboard.
// A second instance with a 4-bit counter exercises saturation cheaply.
module tb_hazard_ctrl;

    localparam logic [5:0] T_LDR  = 6'b101001;
    localparam logic [5:0] T_MUL  = 6'b000011;
    localparam logic [5:0] T_MULI = 6'b001011;
    localparam logic [5:0] T_JMP  = 6'b111000;
    localparam logic [5:0] T_JEQ  = 6'b111001;
    localparam logic [5:0] T_ADD  = 6'b000001;
    localparam logic [5:0] T_3F   = 6'b111111;

    // {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pc_redirect, mul_busy}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_LU   = 7'b1101000;
    localparam logic [6:0] E_MUL  = 7'b1110001;
    localparam logic [6:0] E_BUSY = 7'b0000001;
    localparam logic [6:0] E_BR   = 7'b0001110;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic [3:0] rd;
        logic       rw;
    } instr_t;

    typedef struct packed {
        logic       rst;
        instr_t     in;
        logic       tk;
        logic [6:0] exp;
    } vec_t;

    typedef struct packed {
        logic [6:0]  o;
        logic [31:0] c;
        logic [31:0] n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write;
    logic        ex_taken;
    logic        stall_if, stall_id, stall_ex, bubble_ex;
    logic        flush_id, pc_redirect, mul_busy;
    logic [15:0] stall_cnt;
    logic        s2_if, s2_id, s2_ex, b2_ex, f2_id, r2_pc, m2_busy;
    logic [3:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;
    int vec_no = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .MUL_LAT(3), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .ex_taken(ex_taken), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .pc_redirect(pc_redirect), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.REG_W(4), .MUL_LAT(3), .PERF_W(4)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .ex_taken(ex_taken), .stall_if(s2_if), .stall_id(s2_id),
        .stall_ex(s2_ex), .bubble_ex(b2_ex), .flush_id(f2_id),
        .pc_redirect(r2_pc), .mul_busy(m2_busy), .stall_cnt(stall_cnt2)
    );

    function automatic instr_t ins(input logic v, input logic [5:0] op,
                                   input logic [3:0] rs1, input logic [3:0] rs2,
                                   input logic u1, input logic u2,
                                   input logic [3:0] rd, input logic rw);
        instr_t t;
        t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2;
        t.u1 = u1; t.u2 = u2; t.rd = rd; t.rw = rw;
        return t;
    endfunction

    function automatic vec_t mk(input logic r, input instr_t i,
                                input logic tk, input logic [6:0] e);
        vec_t x;
        x.rst = r; x.in = i; x.tk = tk; x.exp = e;
        return x;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        logic [6:0] got, got2;
        int exp2;
        @(posedge clk);
        #1;
        rst          = v.rst;
        id_valid     = v.in.v;
        id_opcode    = v.in.op;
        id_rs1       = v.in.rs1;
        id_rs2       = v.in.rs2;
        id_use_rs1   = v.in.u1;
        id_use_rs2   = v.in.u2;
        id_rd        = v.in.rd;
        id_reg_write = v.in.rw;
        ex_taken     = v.tk;
        e.o = v.exp;
        e.c = run_cnt;
        e.n = vec_no;
        sb.push_back(e);
        if (v.rst) run_cnt = 0;
        else if (v.exp[6]) run_cnt++;
        @(negedge clk);
        e = sb.pop_front();
        got  = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pc_redirect, mul_busy};
        got2 = {s2_if, s2_id, s2_ex, b2_ex, f2_id, r2_pc, m2_busy};
        exp2 = (e.c > 15) ? 15 : int'(e.c);
        checks++;
        if (got !== e.o) begin
            errors++;
            $display("FAIL strobes vec %0d: got %b want %b", e.n, got, e.o);
        end
        checks++;
        if (stall_cnt !== 16'(e.c)) begin
            errors++;
            $display("FAIL stall_cnt vec %0d: got %0d want %0d", e.n, stall_cnt, e.c);
        end
        checks++;
        if (got2 !== e.o || stall_cnt2 !== 4'(exp2)) begin
            errors++;
            $display("FAIL sat_dut vec %0d: got %b/%0d want %b/%0d",
                     e.n, got2, stall_cnt2, e.o, exp2);
        end
        vec_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t nop, ldr3, add435, mul211, add622, muli21, ldr7, add870;
        instr_t jeq, add9, jmp, op3f, jeq3, add433, ldr0, add550;
        instr_t addnu, ldr5, inv5;
        vec_t tbl[$];

        nop    = ins(0, T_ADD,  0, 0, 0, 0, 0,  0);
        ldr3   = ins(1, T_LDR,  1, 0, 1, 0, 3,  1);
        add435 = ins(1, T_ADD,  3, 5, 1, 1, 4,  1);
        mul211 = ins(1, T_MUL,  1, 1, 1, 1, 2,  1);
        add622 = ins(1, T_ADD,  2, 2, 1, 1, 6,  1);
        muli21 = ins(1, T_MULI, 1, 0, 1, 0, 2,  1);
        ldr7   = ins(1, T_LDR,  1, 0, 1, 0, 7,  1);
        add870 = ins(1, T_ADD,  7, 0, 1, 1, 8,  1);
        jeq    = ins(1, T_JEQ,  0, 0, 0, 0, 0,  0);
        add9   = ins(1, T_ADD,  9, 9, 1, 1, 10, 1);
        jmp    = ins(1, T_JMP,  0, 0, 0, 0, 0,  0);
        op3f   = ins(1, T_3F,   0, 0, 0, 0, 0,  0);
        jeq3   = ins(1, T_JEQ,  3, 0, 1, 0, 3,  0);
        add433 = ins(1, T_ADD,  3, 3, 1, 1, 4,  1);
        ldr0   = ins(1, T_LDR,  1, 0, 1, 0, 0,  1);
        add550 = ins(1, T_ADD,  5, 0, 1, 1, 5,  1);
        addnu  = ins(1, T_ADD,  0, 0, 0, 0, 1,  1);
        ldr5   = ins(1, T_LDR,  1, 0, 1, 0, 5,  1);
        inv5   = ins(0, T_ADD,  5, 0, 1, 0, 6,  1);

        // reset state, then load-use
        tbl.push_back(mk(0, nop,    0, E_NONE));
        tbl.push_back(mk(0, ldr3,   0, E_NONE));
        tbl.push_back(mk(0, add435, 0, E_LU));
        tbl.push_back(mk(0, add435, 0, E_NONE));
        tbl.push_back(mk(0, nop,    0, E_NONE));
        // MUL with 3-cycle latency
        tbl.push_back(mk(0, mul211, 0, E_NONE));
        tbl.push_back(mk(0, add622, 0, E_MUL));
        tbl.push_back(mk(0, add622, 0, E_MUL));
        tbl.push_back(mk(0, add622, 0, E_BUSY));
        tbl.push_back(mk(0, nop,    0, E_NONE));
        // MULI, then load-use against the instruction released after MUL
        tbl.push_back(mk(0, muli21, 0, E_NONE));
        tbl.push_back(mk(0, ldr7,   0, E_MUL));
        tbl.push_back(mk(0, ldr7,   0, E_MUL));
        tbl.push_back(mk(0, ldr7,   0, E_BUSY));
        tbl.push_back(mk(0, add870, 0, E_LU));
        tbl.push_back(mk(0, add870, 0, E_NONE));
        // conditional and unconditional jumps
        tbl.push_back(mk(0, jeq,    0, E_NONE));
        tbl.push_back(mk(0, add9,   1, E_BR));
        tbl.push_back(mk(0, jeq,    1, E_NONE));
        tbl.push_back(mk(0, add9,   0, E_NONE));
        tbl.push_back(mk(0, jmp,    0, E_NONE));
        tbl.push_back(mk(0, nop,    0, E_BR));
        tbl.push_back(mk(0, op3f,   0, E_NONE));
        tbl.push_back(mk(0, nop,    1, E_NONE));
        // jump stalled behind a load, then taken with a dependent ID
        tbl.push_back(mk(0, ldr3,   0, E_NONE));
        tbl.push_back(mk(0, jeq3,   0, E_LU));
        tbl.push_back(mk(0, jeq3,   0, E_NONE));
        tbl.push_back(mk(0, add433, 1, E_BR));
        // r0 compared normally; use flags and id_valid gate the check
        tbl.push_back(mk(0, ldr0,   0, E_NONE));
        tbl.push_back(mk(0, add550, 0, E_LU));
        tbl.push_back(mk(0, add550, 0, E_NONE));
        tbl.push_back(mk(0, ldr0,   0, E_NONE));
        tbl.push_back(mk(0, addnu,  0, E_NONE));
        tbl.push_back(mk(0, ldr5,   0, E_NONE));
        tbl.push_back(mk(0, inv5,   0, E_NONE));
        // reset while MUL_WAIT with cnt=1
        tbl.push_back(mk(0, mul211, 0, E_NONE));
        tbl.push_back(mk(0, add622, 0, E_MUL));
        tbl.push_back(mk(1, add622, 0, E_MUL));
        tbl.push_back(mk(0, add622, 0, E_NONE));
        tbl.push_back(mk(0, nop,    0, E_NONE));

        rst = 1'b1;
        id_valid = 1'b0; id_opcode = T_ADD; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0;
        id_reg_write = 1'b0; ex_taken = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) apply(tbl[i]);

        // back-to-back load-use pairs drive the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, ldr3,   0, E_NONE));
            apply(mk(0, add435, 0, E_LU));
            apply(mk(0, add435, 0, E_NONE));
        end
        apply(mk(0, nop, 0, E_NONE));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
